fifo_sym_sched: RTL and testbench
=================================

// Module: fifo_sym_sched
// PURPOSE
//  Read-side controller for the input word FIFO of the Viterbi decoder. Schedules FIFO reads for one
//  frame of FRAME_LEN words and unpacks each WIDTH-bit word into SYM_W-bit symbols, MSB first.
//  Symbols go to the branch-metric/ACS core over a valid/ready handshake, with SOF/EOF markers.
//  Sits between the FIFO (registered dout, 1-cycle read latency) and the decoder core.
// PARAMETERS
//  WIDTH    16  FIFO word width; WIDTH % SYM_W == 0 is mandatory (elaboration-time check)
//  SYM_W    2   bits per code symbol (rate-1/2 hard decision = 2)
//  LEN_W    16  width of frame length (in FIFO words)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous, active-low reset
//  start_i      in   1       frame start pulse; ignored while busy_o=1
//  frame_len_i  in   LEN_W   words in frame; sampled only on the accepted start_i cycle
//  flush_i      in   1       synchronous abort; highest priority
//  fifo_rd_en_o out  1       FIFO read enable
//  fifo_dout_i  in   WIDTH   FIFO read data; valid the cycle after fifo_rd_en_o=1
//  fifo_empty_i in   1       FIFO empty flag
//  sym_o        out  SYM_W   current symbol
//  sym_valid_o  out  1       symbol valid
//  sym_ready_i  in   1       core accepts symbol
//  sof_o        out  1       qualifies the first symbol of the frame
//  eof_o        out  1       qualifies the last symbol of the frame
//  busy_o       out  1       state != IDLE
//  done_o       out  1       1-cycle pulse after the last symbol is accepted
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, shift register and counters 0.
//  SPW = WIDTH/SYM_W symbols per word. words_left is LEN_W bits. sym_idx is $clog2(SPW) bits.
//  IDLE : start_i with len=0 -> DONE. start_i with len>0 -> latch words_left=len -> FETCH.
//  FETCH: fifo_rd_en_o = !fifo_empty_i (combinational from state). If not empty -> LOAD.
//         If empty -> stay in FETCH; no read and no symbol output.
//  LOAD : capture fifo_dout_i into shreg. sym_idx=0. words_left-=1. -> SHIFT.
//  SHIFT: sym_o = shreg[WIDTH-1 -: SYM_W]; sym_valid_o=1.
//         On valid & ready: shreg <<= SYM_W and sym_idx++.
//         On the last symbol of the word (sym_idx = SPW-1): go to FETCH if words_left != 0, else DONE.
//  DONE : done_o=1 for exactly 1 cycle -> IDLE.
//  Handshake: once asserted, sym_valid_o, sym_o, sof_o and eof_o stay stable until ready. No combinational ready->valid path.
//  sof_o = SHIFT & first word of the frame & sym_idx=0.
//  eof_o = SHIFT & words_left=0 & sym_idx=SPW-1.
//  Latency: start_i (FIFO non-empty) -> FETCH at +1 -> LOAD at +2 -> first sym_valid_o at +3.
//  Word boundary costs 2 bubble cycles (FETCH, LOAD). Prefetch is out of scope for this revision.
//  Never reads when fifo_empty_i=1. Issues exactly one fifo_rd_en_o pulse per frame word.
//  flush_i: any state -> IDLE at the next edge. sym_valid_o/busy_o are 0 the next cycle; no done_o.
//         A word read in the FETCH cycle before the flush is discarded; it has already left the FIFO.
//  start_i and flush_i in the same cycle: flush wins and start is dropped.
//  Async reset mid-frame: outputs clear immediately; the FIFO is reset by the same rst_n.
// STRUCTURE
//  Shared package viterbi_pkg:
//    - state enum sched_state_t {IDLE, FETCH, LOAD, SHIFT, DONE}
//    - localparams for SYM_W default and symbols-per-word
//  Sub-module sym_piso: WIDTH-bit load/shift register with sym_idx counter and last-symbol flag.
//  The FSM and frame counter stay in fifo_sym_sched.
// TESTING
//  T1 basic: FIFO={0xA5C3,0x0F0F}, len=2, ready=1.
//     -> sym 2,2,1,1,3,0,0,3 then 0,0,3,3,0,0,3,3.
//     -> sof on the 1st symbol, eof on the 16th, done_o 1 cycle later, exactly 2 fifo_rd_en_o pulses.
//  T2 backpressure: ready=0 for 5 cycles while sym_o=1 (3rd symbol of 0xA5C3).
//     -> sym_o=1 and sym_valid_o=1 held stable; the sequence is otherwise unchanged.
//  T3 empty stall: start with len=1 on an empty FIFO, write 0xFFFF at +10.
//     -> fifo_rd_en_o=0 until empty drops; then 8 symbols of 3; then done_o.
//  T4 zero length: len=0.
//     -> done_o at start+1, no fifo_rd_en_o, sym_valid_o never 1.
//  T5 flush: len=3, flush_i during the 2nd word's SHIFT.
//     -> sym_valid_o=0 and busy_o=0 next cycle, no done_o; a following start with len=1 decodes the next FIFO word.
//  T6 reset/collision: rst_n low mid-frame -> all outputs 0 asynchronously.
//     start_i+flush_i together -> remains IDLE.

Source files
------------

// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi decoder front end.
//   sched_state_t : read-scheduler FSM states (IDLE, FETCH, LOAD, SHIFT, DONE)
//   SYM_W_DEF     : default bits per code symbol (rate-1/2 hard decision)
//   WIDTH_DEF     : default FIFO word width
//   SPW_DEF       : default symbols per FIFO word
//   idx_width()   : width of a symbol index counter for a given symbols-per-word
// ---------------------------------------------------------------------------
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  localparam int SYM_W_DEF = 2;
  localparam int WIDTH_DEF = 16;
  localparam int SPW_DEF   = WIDTH_DEF / SYM_W_DEF;

  // A single-symbol word still needs a 1-bit index so the port never
  // collapses to zero width.
  function automatic int idx_width(input int spw);
    return (spw > 1) ? $clog2(spw) : 1;
  endfunction

endpackage

// File: rtl/sym_piso.sv
// ---------------------------------------------------------------------------
// sym_piso
// Parallel-in / serial-out symbol register. A FIFO word is loaded whole and
// then presented SYM_W bits at a time, most significant symbol first.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : capture i_din and restart the symbol index at 0
//   i_shift     : advance to the next symbol (ignored while i_load is high)
//   i_din       : WIDTH-bit word to unpack
//   o_sym       : current symbol (top SYM_W bits of the register)
//   o_sym_idx   : index of the current symbol within the word
//   o_last      : current symbol is the last one of the word
// ---------------------------------------------------------------------------
module sym_piso
  import viterbi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYM_W = SYM_W_DEF,
  parameter int IDX_W = idx_width(WIDTH_DEF / SYM_W_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic [SYM_W-1:0] o_sym,
  output logic [IDX_W-1:0] o_sym_idx,
  output logic             o_last
);

  localparam int SPW = WIDTH / SYM_W;

  logic [WIDTH-1:0] r_shreg;
  logic [IDX_W-1:0] r_idx;

  // Load wins over shift so a fresh word always starts at symbol 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shreg <= i_din;
      r_idx   <= '0;
    end else if (i_shift) begin
      r_shreg <= r_shreg << SYM_W;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  assign o_sym     = r_shreg[WIDTH-1 -: SYM_W];
  assign o_sym_idx = r_idx;
  assign o_last    = (r_idx == IDX_W'(SPW - 1));

endmodule

// File: rtl/fifo_sym_sched.sv
// ---------------------------------------------------------------------------
// fifo_sym_sched
// Read-side controller for the Viterbi decoder input FIFO. For one frame of
// frame_len_i words it reads the FIFO once per word, unpacks each word into
// SYM_W-bit symbols (MSB first) and hands them to the decoder core over a
// valid/ready handshake with start/end-of-frame markers.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : frame start pulse, accepted only when idle
//   frame_len_i   : frame length in FIFO words, sampled with an accepted start
//   flush_i       : synchronous abort back to idle, highest priority
//   fifo_rd_en_o  : FIFO read enable
//   fifo_dout_i   : FIFO read data, valid the cycle after a read
//   fifo_empty_i  : FIFO empty flag
//   sym_o         : current symbol
//   sym_valid_o   : symbol valid
//   sym_ready_i   : core accepts the symbol
//   sof_o / eof_o : first / last symbol of the frame
//   busy_o        : controller not idle
//   done_o        : one-cycle pulse after the last symbol is accepted
// ---------------------------------------------------------------------------
module fifo_sym_sched
  import viterbi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYM_W = SYM_W_DEF,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic             flush_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_dout_i,
  input  logic             fifo_empty_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  input  logic             sym_ready_i,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SPW   = WIDTH / SYM_W;
  localparam int IDX_W = idx_width(SPW);

  // A word must split into a whole number of symbols.
  if ((WIDTH % SYM_W) != 0) begin : g_width_check
    $error("fifo_sym_sched: WIDTH must be a multiple of SYM_W");
  end

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [LEN_W-1:0] r_words_left;
  logic             r_first_word;

  logic             w_in_shift;
  logic             w_accept;
  logic             w_load;
  logic [SYM_W-1:0] w_sym;
  logic [IDX_W-1:0] w_sym_idx;
  logic             w_last;

  assign w_in_shift = (r_state == SHIFT);
  assign w_accept   = w_in_shift && sym_ready_i;
  assign w_load     = (r_state == LOAD);

  sym_piso #(
    .WIDTH (WIDTH),
    .SYM_W (SYM_W),
    .IDX_W (IDX_W)
  ) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_shift   (w_accept),
    .i_din     (fifo_dout_i),
    .o_sym     (w_sym),
    .o_sym_idx (w_sym_idx),
    .o_last    (w_last)
  );

  // Next-state logic. Flush overrides everything, including a coincident
  // start, so a start in the flush cycle is simply dropped.
  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start_i) w_next = (frame_len_i == '0) ? DONE : FETCH;
        FETCH:   if (!fifo_empty_i) w_next = LOAD;
        LOAD:    w_next = SHIFT;
        SHIFT:   if (w_accept && w_last) w_next = (r_words_left != '0) ? FETCH : DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // words_left is decremented when a word is loaded, so it reads 0 for the
  // whole of the final word; that is what marks the end-of-frame symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_words_left <= '0;
      r_first_word <= 1'b0;
    end else begin
      r_state <= w_next;
      if (flush_i) begin
        r_words_left <= '0;
        r_first_word <= 1'b0;
      end else if ((r_state == IDLE) && start_i) begin
        r_words_left <= frame_len_i;
        r_first_word <= 1'b1;
      end else if (w_load) begin
        r_words_left <= r_words_left - LEN_W'(1);
      end else if (w_accept && w_last) begin
        r_first_word <= 1'b0;
      end
    end
  end

  // All outputs decode from registered state (plus the FIFO flag for the
  // read strobe), so there is no path from sym_ready_i to sym_valid_o.
  assign fifo_rd_en_o = (r_state == FETCH) && !fifo_empty_i;
  assign sym_valid_o  = w_in_shift;
  assign sym_o        = w_in_shift ? w_sym : '0;
  assign sof_o        = w_in_shift && r_first_word && (w_sym_idx == '0);
  assign eof_o        = w_in_shift && (r_words_left == '0) && w_last;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);

endmodule

// File: tb/tb_fifo_sym_sched.sv
// ---------------------------------------------------------------------------
// tb_fifo_sym_sched
// Directed bench for fifo_sym_sched. A small FIFO model feeds the scheduler;
// expected symbols (with sof/eof flags) are queued as frames are set up and
// popped whenever the bench's monitor sees a symbol handshake.
// ---------------------------------------------------------------------------
module tb_fifo_sym_sched;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [1:0] sym;
  } expSym_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] frame_len_i;
  logic        flush_i;
  logic        fifo_rd_en_o;
  logic [15:0] fifo_dout_i;
  logic        fifo_empty_i;
  logic [1:0]  sym_o;
  logic        sym_valid_o;
  logic        sym_ready_i;
  logic        sof_o;
  logic        eof_o;
  logic        busy_o;
  logic        done_o;

  logic [15:0] fifoMem [0:63];
  int          wrPtr = 0;
  int          rdPtr = 0;

  expSym_t     sbQ [$];

  int checkTotal  = 0;
  int checkPass   = 0;
  int checkFail   = 0;
  int cyc         = 0;
  int rdCount     = 0;
  int emptyReads  = 0;
  int doneCount   = 0;
  int acceptCount = 0;
  int validCount  = 0;
  int doneCyc     = 0;
  int eofCyc      = 0;

  fifo_sym_sched #(
    .WIDTH (16),
    .SYM_W (2),
    .LEN_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .frame_len_i  (frame_len_i),
    .flush_i      (flush_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_dout_i  (fifo_dout_i),
    .fifo_empty_i (fifo_empty_i),
    .sym_o        (sym_o),
    .sym_valid_o  (sym_valid_o),
    .sym_ready_i  (sym_ready_i),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered read data, one-cycle latency, empty when the
  // pointers meet. Only this block moves the read pointer.
  assign fifo_empty_i = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (fifo_rd_en_o && (wrPtr != rdPtr)) begin
      fifo_dout_i <= fifoMem[rdPtr[5:0]];
      rdPtr       <= rdPtr + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkTotal++;
    assert (observed === expected) begin
      checkPass++;
    end else begin
      checkFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushFifo(input logic [15:0] word);
    fifoMem[wrPtr[5:0]] = word;
    wrPtr = wrPtr + 1;
  endtask

  // Expected symbols of one word, MSB pair first.
  task automatic pushWord(input logic [15:0] word, input logic first, input logic last);
    expSym_t e;
    for (int k = 0; k < 8; k++) begin
      e.sym = 2'(word >> (14 - 2 * k));
      e.sof = first && (k == 0);
      e.eof = last && (k == 7);
      sbQ.push_back(e);
    end
  endtask

  // One clock: monitor at the falling edge (inputs here are the ones the
  // DUT sees at the next rising edge), then return just after that edge.
  task automatic stepCycle();
    expSym_t e;
    @(negedge clk);
    cyc++;
    if (fifo_rd_en_o) begin
      rdCount++;
      if (fifo_empty_i) emptyReads++;
    end
    if (done_o) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (sym_valid_o) validCount++;
    if (sym_valid_o && sym_ready_i) begin
      acceptCount++;
      checkOutput("sb_has_entry", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("sym_sof_eof", 32'({sof_o, eof_o, sym_o}), 32'(e));
      end
      if (eof_o) eofCyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] len);
    frame_len_i = len;
    start_i     = 1'b1;
    stepCycle();
    start_i     = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int doneBase, input int budget);
    int n = 0;
    while ((doneCount == doneBase) && (n < budget)) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(doneCount - doneBase), 32'd1);
  endtask

  task automatic waitAccepts(input string tag, input int target, input int budget);
    int n = 0;
    while ((acceptCount < target) && (n < budget)) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(acceptCount >= target), 32'd1);
  endtask

  initial begin
    int rdBase;
    int doneBase;
    int accBase;
    int validBase;
    int holdBad;
    int stallBad;

    rst_n       = 1'b0;
    start_i     = 1'b0;
    flush_i     = 1'b0;
    frame_len_i = '0;
    sym_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                32'({sym_valid_o, sof_o, eof_o, busy_o, done_o, fifo_rd_en_o, sym_o}), 32'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle_after_reset", 32'(busy_o), 32'd0);

    // T1: two-word frame, core always ready
    $display("[TB] T1 basic frame");
    pushFifo(16'hA5C3);
    pushFifo(16'h0F0F);
    pushWord(16'hA5C3, 1'b1, 1'b0);
    pushWord(16'h0F0F, 1'b0, 1'b1);
    rdBase   = rdCount;
    doneBase = doneCount;
    applyStimulus(16'd2);
    checkOutput("t1_fetch_rd_en", 32'({busy_o, fifo_rd_en_o, sym_valid_o}), 32'b110);
    stepCycle();
    checkOutput("t1_load_no_valid", 32'(sym_valid_o), 32'd0);
    stepCycle();
    checkOutput("t1_first_sym", 32'({sym_valid_o, sof_o, sym_o}), 32'b1110);
    waitDone("t1_done", doneBase, 100);
    checkOutput("t1_done_one_cycle", 32'({done_o, busy_o}), 32'd0);
    checkOutput("t1_done_after_eof", 32'(doneCyc - eofCyc), 32'd1);
    checkOutput("t1_rd_pulses", 32'(rdCount - rdBase), 32'd2);
    checkOutput("t1_sb_drained", 32'(sbQ.size()), 32'd0);

    // T2: hold the third symbol (value 1) for five cycles
    $display("[TB] T2 backpressure");
    pushFifo(16'hA5C3);
    pushFifo(16'h0F0F);
    pushWord(16'hA5C3, 1'b1, 1'b0);
    pushWord(16'h0F0F, 1'b0, 1'b1);
    rdBase   = rdCount;
    doneBase = doneCount;
    applyStimulus(16'd2);
    accBase = acceptCount;
    waitAccepts("t2_two_accepted", accBase + 2, 50);
    sym_ready_i = 1'b0;
    holdBad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(sym_valid_o && (sym_o == 2'd1) && !sof_o && !eof_o)) holdBad++;
      stepCycle();
    end
    checkOutput("t2_hold_stable", 32'(holdBad), 32'd0);
    checkOutput("t2_sym_held", 32'({sym_valid_o, sym_o}), 32'b101);
    checkOutput("t2_no_accept_stalled", 32'(acceptCount - accBase), 32'd2);
    sym_ready_i = 1'b1;
    waitDone("t2_done", doneBase, 100);
    checkOutput("t2_rd_pulses", 32'(rdCount - rdBase), 32'd2);
    checkOutput("t2_sb_drained", 32'(sbQ.size()), 32'd0);

    // T3: start on an empty FIFO, word arrives ten cycles later
    $display("[TB] T3 empty stall");
    rdBase   = rdCount;
    doneBase = doneCount;
    applyStimulus(16'd1);
    stallBad = 0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_en_o || sym_valid_o || !busy_o) stallBad++;
      stepCycle();
    end
    checkOutput("t3_stall_quiet", 32'(stallBad), 32'd0);
    checkOutput("t3_no_read_empty", 32'(rdCount - rdBase), 32'd0);
    pushWord(16'hFFFF, 1'b1, 1'b1);
    pushFifo(16'hFFFF);
    waitDone("t3_done", doneBase, 50);
    checkOutput("t3_rd_pulses", 32'(rdCount - rdBase), 32'd1);
    checkOutput("t3_sb_drained", 32'(sbQ.size()), 32'd0);

    // T4: zero-length frame goes straight to DONE
    $display("[TB] T4 zero length");
    rdBase    = rdCount;
    doneBase  = doneCount;
    validBase = validCount;
    applyStimulus(16'd0);
    checkOutput("t4_done_plus1", 32'({done_o, busy_o}), 32'b11);
    stepCycle();
    stepCycle();
    checkOutput("t4_back_idle", 32'({done_o, busy_o}), 32'd0);
    checkOutput("t4_done_count", 32'(doneCount - doneBase), 32'd1);
    checkOutput("t4_no_read", 32'(rdCount - rdBase), 32'd0);
    checkOutput("t4_no_valid", 32'(validCount - validBase), 32'd0);

    // T5: flush in the second word, then a one-word frame takes word 3
    $display("[TB] T5 flush");
    pushFifo(16'h1B1B);
    pushFifo(16'h2C2C);
    pushFifo(16'h3D3D);
    pushWord(16'h1B1B, 1'b1, 1'b0);
    pushWord(16'h2C2C, 1'b0, 1'b0);
    applyStimulus(16'd3);
    accBase = acceptCount;
    waitAccepts("t5_into_word2", accBase + 11, 60);
    doneBase    = doneCount;
    sym_ready_i = 1'b0;
    flush_i     = 1'b1;
    stepCycle();
    flush_i     = 1'b0;
    checkOutput("t5_flush_idle", 32'({sym_valid_o, busy_o}), 32'd0);
    sbQ.delete();
    sym_ready_i = 1'b1;
    repeat (5) stepCycle();
    checkOutput("t5_no_done", 32'(doneCount - doneBase), 32'd0);
    pushWord(16'h3D3D, 1'b1, 1'b1);
    rdBase   = rdCount;
    doneBase = doneCount;
    applyStimulus(16'd1);
    waitDone("t5_next_done", doneBase, 50);
    checkOutput("t5_next_rd", 32'(rdCount - rdBase), 32'd1);
    checkOutput("t5_sb_drained", 32'(sbQ.size()), 32'd0);

    // T6: asynchronous reset mid-frame, then start+flush collision
    $display("[TB] T6 reset and collision");
    pushFifo(16'h1234);
    pushWord(16'h1234, 1'b1, 1'b1);
    applyStimulus(16'd1);
    accBase = acceptCount;
    waitAccepts("t6_mid_frame", accBase + 2, 50);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset",
                32'({sym_valid_o, sof_o, eof_o, busy_o, done_o, fifo_rd_en_o, sym_o}), 32'd0);
    sbQ.delete();
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("t6_idle_after_reset", 32'(busy_o), 32'd0);
    frame_len_i = 16'd5;
    start_i     = 1'b1;
    flush_i     = 1'b1;
    stepCycle();
    start_i     = 1'b0;
    flush_i     = 1'b0;
    checkOutput("t6_collision_idle", 32'({busy_o, fifo_rd_en_o}), 32'd0);
    stepCycle();
    checkOutput("t6_collision_stays", 32'(busy_o), 32'd0);

    checkOutput("never_read_empty", 32'(emptyReads), 32'd0);

    $display("%0d/%0d checks passed", checkPass, checkTotal);
    $finish;
  end

endmodule
